// File: rtl/rr_stream_mux_pkg.sv
// Shared helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

   // Advance a channel index by one.
   // Wraps explicitly to 0 after n-1, so a non-power-of-two channel count
   // never produces an out-of-range index.
   function automatic int next_idx(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The request vector is rotated so that position 0 corresponds to the
// priority pointer. The lowest set bit of the rotated vector is then
// mapped back to an absolute channel index.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic [CH_W-1:0] gnt_idx,
   output logic            gnt_any
);

   logic [N_CH-1:0] rot;

   // Map an offset relative to the pointer back to an absolute channel index.
   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= N_CH) s = s - N_CH;
      return CH_W'(s);
   endfunction

   // Rotate-and-priority-encode.
   // Scanning downwards lets the lowest rotated position win.
   always_comb begin
      rot     = N_CH'({req, req} >> ptr);
      gnt_any = |req;
      gnt_idx = '0;
      for (int j = N_CH - 1; j >= 0; j--) begin
         if (rot[j]) gnt_idx = wrap_add(ptr, j);
      end
   end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel stream multiplexer.
// Features:
//  - round-robin arbitration between the input channels;
//  - optional per-transfer data inversion;
//  - a single registered valid/ready output stage.
module rr_stream_mux
   import rr_stream_mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 8,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH*W-1:0] in_data,
   output logic [N_CH-1:0]   in_ready,
   input  logic              invert,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [CH_W-1:0]   out_ch,
   input  logic              out_ready
);

   logic [CH_W-1:0] ptr;
   logic [CH_W-1:0] gnt_idx;
   logic            gnt_any;
   logic            accept;
   logic [W-1:0]    sel_data;

   logic            vld_p0;
   logic [W-1:0]    data_p0;
   logic [CH_W-1:0] ch_p0;

   // Mode stage: pass the selected word through or complement it.
   function automatic logic [W-1:0] apply_mode(input logic [W-1:0] d, input logic inv);
      return inv ? ~d : d;
   endfunction

   rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_arb (
      .req     (in_valid),
      .ptr     (ptr),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Handshake and data selection.
   // Reset blocks acceptance, so no producer sees its word taken while the
   // output register is being cleared.
   always_comb begin
      accept   = !rst && (!vld_p0 || out_ready) && gnt_any;
      in_ready = '0;
      if (accept) in_ready[gnt_idx] = 1'b1;
      sel_data = in_data[int'(gnt_idx) * W +: W];
   end

   // Output register and priority pointer.
   // Behaviour:
   //  - on accept: load the new word and advance the pointer past the granted channel;
   //  - on a pop with no refill: clear valid only;
   //  - on a stall: hold everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         ch_p0   <= '0;
         ptr     <= '0;
      end else if (accept) begin
         vld_p0  <= 1'b1;
         data_p0 <= apply_mode(sel_data, invert);
         ch_p0   <= gnt_idx;
         ptr     <= CH_W'(next_idx(int'(gnt_idx), N_CH));
      end else if (vld_p0 && out_ready) begin
         vld_p0  <= 1'b0;
      end
   end

   assign out_valid = vld_p0;
   assign out_data  = data_p0;
   assign out_ch    = ch_p0;

endmodule
